nonce_buffer: RTL
=================

# nonce_buffer

Receiving end of the miner's nonce-buffer path. Captures each winning nonce reported by the miner, holds it in a small FIFO, and drains entries to the host side as a byte stream under a valid/ready handshake, most-significant byte first. Drops that occur because the FIFO is full, and nonce-space exhaustion reported by the miner, set a sticky overflow flag that host logic clears explicitly.

## Interface
- DEPTH, 4, number of nonce entries stored; power of two, ≥2
- NONCE_W, 32, nonce width in bits; multiple of 8

- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- resultValid  in  1  miner result strobe, one cycle per result
- success  in  1  qualifies resultValid; result carries a winning nonce
- nonce  in  NONCE_W  winning nonce, sampled when resultValid && success
- ovf_in  in  1  miner overflow; nonce space exhausted
- tx_data  out  8  current output byte
- tx_valid  out  1  tx_data holds a valid byte
- tx_ready  in  1  host accepts the byte this cycle
- count  out  $clog2(DEPTH)+1  entries held, including the one being drained
- overflow  out  1  sticky loss/exhaustion flag
- clear_ovf  in  1  clears overflow

## Operation
- Push: an entry is written when resultValid && success. resultValid with success low is ignored.
- Full: when count == DEPTH at the sampling edge, the push is dropped and overflow is set. This holds even if the head entry finishes draining in the same cycle; there is no push-through.
- FIFO: circular buffer with read and write pointers that wrap modulo DEPTH. count increments on an accepted push and decrements on pop. A push and a pop in the same cycle leave count unchanged.
- Serializer FSM, two states:
  - IDLE: tx_valid = 0 and tx_data = 0. Moves to SEND at the next edge when count > 0.
  - SEND: tx_valid = 1 and tx_data = byte[idx] of the head entry, where idx 0 is bits [NONCE_W-1:NONCE_W-8].
    - A handshake (tx_valid && tx_ready) advances idx.
    - A handshake on idx = NONCE_W/8-1 pops the head and resets idx to 0. The FSM stays in SEND if entries remain after the pop; otherwise it returns to IDLE.
- Handshake rule: while tx_valid && !tx_ready, tx_data and tx_valid hold stable. A push into a non-empty FIFO does not disturb the head entry.
- Overflow flag:
  - Set by a dropped push, or by ovf_in high on any cycle.
  - Cleared by clear_ovf.
  - If a set condition and clear_ovf occur in the same cycle, the set wins.
- Reset values: count 0, pointers 0, idx 0, state IDLE, tx_valid 0, tx_data 0, overflow 0. Reset in the middle of a frame discards the partly sent nonce and all stored entries; nothing resumes after reset.

## Timing
- Strobe accepted in cycle k:
  - count reflects the new entry in cycle k+1.
  - If the FIFO was empty, tx_valid rises in cycle k+2 carrying byte 0.
- With tx_ready held high, one byte is transferred per cycle. A NONCE_W=32 entry takes 4 cycles.
- Back-to-back entries: if the last byte handshakes in cycle j and entries remain, cycle j+1 presents byte 0 of the next entry with tx_valid still high (no bubble).
- After the final entry's last handshake in cycle j, tx_valid is 0 in cycle j+1.
- overflow updates the cycle after its cause; count updates the cycle after push or pop.

## Test plan
- Single nonce 0xDEADBEEF with tx_ready held high → tx_valid high for exactly 4 cycles starting 2 cycles after the strobe, bytes DE, AD, BE, EF; count goes 0→1→0; overflow stays 0.
- Backpressure: same nonce, tx_ready toggling 1,0,0,1,0,1,1 → each byte held stable while stalled; sequence DE, AD, BE, EF with no byte duplicated or skipped.
- Fill: tx_ready = 0, five successive strobes with nonces 1..5 → count saturates at 4 and overflow = 1. Then tx_ready = 1 → 16 bytes are output (nonces 1..4, each MSB first) with no bubbles; nonce 5 is never output.
- Ignore and wrap: a strobe with resultValid = 1, success = 0 → no push. Then 10 pushes interleaved with drains → output order matches input order across pointer wrap.
- Overflow: ovf_in pulsed for one cycle → overflow = 1. clear_ovf asserted in the same cycle as a dropped push → overflow stays 1. clear_ovf alone → overflow = 0.
- rst asserted after byte 1 of 3 queued nonces → next cycle shows tx_valid = 0, count = 0, tx_data = 0. A new strobe afterwards produces a clean 4-byte frame.

Source files
------------

// File: rtl/nonce_buffer_if.sv
// Byte-stream link from the nonce buffer to the host.
// The master presents a byte with a valid flag; the slave accepts it with ready.
interface nonce_buffer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/nonce_buffer.sv
// Nonce buffer: captures winning nonces into a small FIFO and streams them
// to the host MSB first, with a sticky overflow flag for lost results.
module nonce_buffer #(
   parameter int DEPTH   = 4,
   parameter int NONCE_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   resultValid,
   input  logic                   success,
   input  logic [NONCE_W-1:0]     nonce,
   input  logic                   ovf_in,
   nonce_buffer_if.master         tx,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   clear_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int NB = NONCE_W / 8;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t             state;
   logic [NONCE_W-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [IW-1:0]      idx;

   logic               push_req;
   logic               full;
   logic               push;
   logic               hs;
   logic               pop;
   logic [NONCE_W-1:0] head;
   logic [NONCE_W-1:0] next_head;

   function automatic logic [7:0] byte_sel(
      input logic [NONCE_W-1:0] w,
      input logic [IW-1:0]      i
   );
      logic [NONCE_W-1:0] s;
      s = w << {i, 3'b000};
      return s[NONCE_W-1 -: 8];
   endfunction

   assign push_req = resultValid && success;
   assign full     = (count == CW'(DEPTH));
   assign push     = push_req && !full;
   assign hs       = tx.tx_valid && tx.tx_ready;
   assign pop      = hs && (idx == LAST);
   assign head     = mem[rd_ptr];
   // With a single entry left, the follow-on entry is the one being
   // written this very cycle, so take it straight from the input.
   assign next_head = (count == CW'(1)) ? nonce : mem[rd_ptr + 1'b1];

   // Store accepted nonces at the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= nonce;
      end
   end

   // Track FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Sticky overflow; a new cause beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (ovf_in || (push_req && full)) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

   // Serializer FSM with registered byte and valid outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  state       <= SEND;
                  idx         <= '0;
                  tx.tx_valid <= 1'b1;
                  tx.tx_data  <= byte_sel(head, '0);
               end
            end
            SEND: begin
               if (hs) begin
                  if (idx == LAST) begin
                     idx <= '0;
                     if (count > CW'(1) || push) begin
                        tx.tx_data <= byte_sel(next_head, '0);
                     end else begin
                        state       <= IDLE;
                        tx.tx_valid <= 1'b0;
                        tx.tx_data  <= '0;
                     end
                  end else begin
                     idx        <= idx + 1'b1;
                     tx.tx_data <= byte_sel(head, idx + 1'b1);
                  end
               end
            end
         endcase
      end
   end

endmodule
